// File: rtl/clk_div_sequencer_if.sv
// Command channel of the clock-divider sequencer: valid/ready handshake,
// opcode and payload, plus the asynchronous-to-command abort request.
interface clk_div_sequencer_if;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [1:0]  cmd_op;
  logic [31:0] cmd_data;
  logic        abort;

  modport master (output cmd_valid, output cmd_op, output cmd_data, output abort,
                  input  cmd_ready);
  modport slave  (input  cmd_valid, input  cmd_op, input  cmd_data, input  abort,
                  output cmd_ready);
endinterface

// File: rtl/clk_div_sequencer.sv
// Sequences a programmable clock divider: idle, counted pulse bursts (STEP)
// and free-running auto mode, with live divider updates and abort.
module clk_div_sequencer #(
  parameter int COUNTER_BITS       = 32,
  parameter int PULSE_CONTROL_BITS = 32,
  parameter int DEFAULT_DIVIDER    = 2
) (
  input  logic                          clk,
  input  logic                          reset,
  clk_div_sequencer_if.slave            cmd,
  output logic                          div_write_pulse,
  output logic                          div_option,
  output logic                          div_out_enable,
  output logic [COUNTER_BITS-1:0]       div_divider,
  output logic [PULSE_CONTROL_BITS-1:0] div_pulse,
  output logic                          done,
  output logic                          aborted,
  output logic                          err,
  output logic                          busy,
  output logic [1:0]                    state_o
);

  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_LOAD = 2'b01,
    S_RUN  = 2'b10,
    S_FREE = 2'b11
  } state_t;

  localparam logic [1:0] OP_STOP     = 2'b00;
  localparam logic [1:0] OP_SET_DIV  = 2'b01;
  localparam logic [1:0] OP_STEP     = 2'b10;
  localparam logic [1:0] OP_FREE_RUN = 2'b11;

  state_t                        r_state;
  state_t                        w_state_nxt;
  logic [PULSE_CONTROL_BITS-1:0] r_remaining;
  logic [PULSE_CONTROL_BITS-1:0] w_remaining_nxt;
  logic [COUNTER_BITS-1:0]       w_div_data;
  logic [COUNTER_BITS-1:0]       w_divider_nxt;
  logic [PULSE_CONTROL_BITS-1:0] w_step_n;
  logic [PULSE_CONTROL_BITS-1:0] w_pulse_nxt;
  logic                          w_accept;
  logic                          w_div_ok;
  logic                          w_done_nxt;
  logic                          w_err_nxt;
  logic                          w_aborted_nxt;
  logic                          w_write_nxt;

  // Remaining-pulse countdown saturates at zero instead of wrapping.
  function automatic logic [PULSE_CONTROL_BITS-1:0] sat_dec(
    input logic [PULSE_CONTROL_BITS-1:0] v
  );
    return (v == '0) ? '0 : v - PULSE_CONTROL_BITS'(1);
  endfunction

  assign cmd.cmd_ready = (r_state == S_IDLE) || (r_state == S_FREE);
  assign w_accept      = cmd.cmd_valid && cmd.cmd_ready;
  assign w_div_data    = COUNTER_BITS'(cmd.cmd_data);
  assign w_step_n      = PULSE_CONTROL_BITS'(cmd.cmd_data);
  assign w_div_ok      = (w_div_data >= COUNTER_BITS'(2));
  assign state_o       = r_state;

  always_ff @(posedge clk) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE: begin
        if (w_accept && cmd.cmd_op == OP_STEP && w_step_n != '0) w_state_nxt = S_LOAD;
        else if (w_accept && cmd.cmd_op == OP_FREE_RUN)          w_state_nxt = S_FREE;
      end
      S_LOAD:  w_state_nxt = cmd.abort ? S_IDLE : S_RUN;
      S_RUN: begin
        if (cmd.abort || r_remaining <= PULSE_CONTROL_BITS'(1)) w_state_nxt = S_IDLE;
      end
      S_FREE: begin
        if (w_accept && cmd.cmd_op == OP_STOP) w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    w_done_nxt      = 1'b0;
    w_err_nxt       = 1'b0;
    w_aborted_nxt   = 1'b0;
    w_write_nxt     = 1'b0;
    w_divider_nxt   = div_divider;
    w_pulse_nxt     = div_pulse;
    w_remaining_nxt = r_remaining;
    case (r_state)
      S_IDLE, S_FREE: begin
        if (w_accept) begin
          case (cmd.cmd_op)
            OP_STOP: w_done_nxt = 1'b1;
            OP_SET_DIV: begin
              if (w_div_ok) begin
                w_divider_nxt = w_div_data;
                w_done_nxt    = 1'b1;
              end else begin
                w_err_nxt = 1'b1;
              end
            end
            OP_STEP: begin
              if (r_state == S_FREE) begin
                w_err_nxt = 1'b1;
              end else if (w_step_n == '0) begin
                w_done_nxt = 1'b1;
              end else begin
                w_write_nxt     = 1'b1;
                w_pulse_nxt     = w_step_n;
                w_remaining_nxt = w_step_n;
              end
            end
            default: ;
          endcase
        end
      end
      S_LOAD: begin
        if (cmd.abort) begin
          w_done_nxt      = 1'b1;
          w_aborted_nxt   = 1'b1;
          w_remaining_nxt = '0;
        end
      end
      S_RUN: begin
        if (cmd.abort) begin
          w_done_nxt      = 1'b1;
          w_aborted_nxt   = 1'b1;
          w_remaining_nxt = '0;
        end else begin
          w_remaining_nxt = sat_dec(r_remaining);
          if (r_remaining <= PULSE_CONTROL_BITS'(1)) w_done_nxt = 1'b1;
        end
      end
      default: ;
    endcase
  end

  // Output register: mode outputs follow the state being entered so they
  // line up with state_o on the same cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      div_write_pulse <= 1'b0;
      div_option      <= 1'b0;
      div_out_enable  <= 1'b0;
      div_divider     <= COUNTER_BITS'(DEFAULT_DIVIDER);
      div_pulse       <= '0;
      done            <= 1'b0;
      aborted         <= 1'b0;
      err             <= 1'b0;
      busy            <= 1'b0;
      r_remaining     <= '0;
    end else begin
      div_write_pulse <= w_write_nxt;
      div_option      <= (w_state_nxt == S_FREE);
      div_out_enable  <= (w_state_nxt != S_IDLE);
      div_divider     <= w_divider_nxt;
      div_pulse       <= w_pulse_nxt;
      done            <= w_done_nxt;
      aborted         <= w_aborted_nxt;
      err             <= w_err_nxt;
      busy            <= (w_state_nxt != S_IDLE);
      r_remaining     <= w_remaining_nxt;
    end
  end

endmodule

// File: tb/tb_clk_div_sequencer.sv
// Bench for clk_div_sequencer: directed scenarios plus a randomized run
// against a timeline-based reference model.
module tb_clk_div_sequencer;
  localparam int CB  = 32;
  localparam int PB  = 32;
  localparam int DEF = 2;

  localparam logic [1:0] OP_STOP = 2'b00, OP_SET = 2'b01, OP_STEP = 2'b10, OP_FREE = 2'b11;
  // flags = {state[1:0], done, aborted, err, write_pulse, out_enable, option, busy, ready}
  localparam logic [9:0] F_RESET   = 10'b00_0000_0001;
  localparam logic [9:0] F_DONE    = 10'b00_1000_0001;
  localparam logic [9:0] F_ABORTED = 10'b00_1100_0001;
  localparam logic [9:0] F_LOAD    = 10'b01_0001_1010;
  localparam logic [9:0] F_RUN     = 10'b10_0000_1010;
  localparam logic [9:0] F_FREE    = 10'b11_0000_1111;
  localparam logic [9:0] F_FREEERR = 10'b11_0010_1111;

  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  clk_div_sequencer_if cif();
  logic          div_write_pulse, div_option, div_out_enable;
  logic [CB-1:0] div_divider;
  logic [PB-1:0] div_pulse;
  logic          done, aborted, err, busy;
  logic [1:0]    state_o;

  clk_div_sequencer #(
    .COUNTER_BITS(CB), .PULSE_CONTROL_BITS(PB), .DEFAULT_DIVIDER(DEF)
  ) dut (
    .clk(clk), .reset(reset), .cmd(cif),
    .div_write_pulse(div_write_pulse), .div_option(div_option),
    .div_out_enable(div_out_enable), .div_divider(div_divider),
    .div_pulse(div_pulse), .done(done), .aborted(aborted), .err(err),
    .busy(busy), .state_o(state_o)
  );

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  // Model: mode 0 idle, 1 stepping, 2 free-running; a step is a timeline
  // starting at acceptance cycle m_t0 and lasting m_n run cycles.
  int          m_mode = 0;
  int          m_t0 = 0;
  int          m_n = 0;
  logic [31:0] m_div = DEF;
  logic [31:0] m_pulse = '0;
  logic        e_done, e_abt, e_err, e_wp;
  logic [1:0]  e_state;

  function automatic logic [9:0] flags();
    return {state_o, done, aborted, err, div_write_pulse, div_out_enable,
            div_option, busy, cif.cmd_ready};
  endfunction

  function automatic logic [9:0] exp_flags();
    logic act, fr;
    act = (m_mode != 0);
    fr  = (m_mode == 2);
    return {e_state, e_done, e_abt, e_err, e_wp, act, fr, act, (m_mode != 1)};
  endfunction

  task automatic model_update(input logic v, input logic [1:0] op, input logic [31:0] d,
                              input logic ab, input logic rst);
    int   nc;
    logic rdy;
    nc  = cyc + 1;
    rdy = (m_mode != 1);
    e_done = 1'b0; e_abt = 1'b0; e_err = 1'b0; e_wp = 1'b0;
    if (rst) begin
      m_mode = 0; m_div = DEF; m_pulse = '0;
    end else if (m_mode == 1) begin
      if (ab) begin
        m_mode = 0; e_done = 1'b1; e_abt = 1'b1;
      end else if (nc == m_t0 + m_n + 2) begin
        m_mode = 0; e_done = 1'b1;
      end
    end else if (v && rdy) begin
      case (op)
        OP_STOP: begin m_mode = 0; e_done = 1'b1; end
        OP_SET: begin
          if (d >= 2) begin m_div = d; e_done = 1'b1; end
          else e_err = 1'b1;
        end
        OP_STEP: begin
          if (m_mode == 2) e_err = 1'b1;
          else if (d == 0) e_done = 1'b1;
          else begin
            m_mode = 1; m_t0 = cyc; m_n = int'(d); m_pulse = d; e_wp = 1'b1;
          end
        end
        default: m_mode = 2;
      endcase
    end
    if (m_mode == 0)      e_state = 2'b00;
    else if (m_mode == 2) e_state = 2'b11;
    else                  e_state = (nc == m_t0 + 1) ? 2'b01 : 2'b10;
    cyc = nc;
  endtask

  task automatic step(input logic v, input logic [1:0] op, input logic [31:0] d,
                      input logic ab, input logic rst);
    cif.cmd_valid = v; cif.cmd_op = op; cif.cmd_data = d; cif.abort = ab; reset = rst;
    @(posedge clk); #1;
    model_update(v, op, d, ab, rst);
    cif.cmd_valid = 1'b0; cif.abort = 1'b0; reset = 1'b0;
  endtask

  task automatic test_reset();
    step(0, OP_STOP, 0, 0, 1);
    step(1, OP_STEP, 7, 1, 1);
    checks++; if (flags() !== F_RESET) begin errors++;
      $display("FAIL reset_flags got=%b exp=%b", flags(), F_RESET); end
    checks++; if (div_divider !== CB'(DEF)) begin errors++;
      $display("FAIL reset_divider got=%0d exp=%0d", div_divider, DEF); end
    checks++; if (div_pulse !== '0) begin errors++;
      $display("FAIL reset_pulse got=%0d exp=0", div_pulse); end
  endtask

  task automatic test_set_div();
    step(1, OP_SET, 6, 0, 0);
    checks++; if (div_divider !== 32'd6) begin errors++;
      $display("FAIL set_div_value got=%0d exp=6", div_divider); end
    checks++; if (flags() !== F_DONE) begin errors++;
      $display("FAIL set_div_flags got=%b exp=%b", flags(), F_DONE); end
    step(1, OP_SET, 0, 0, 0);
    checks++; if (flags() !== 10'b00_0010_0001 || div_divider !== 32'd6) begin errors++;
      $display("FAIL set_div_zero flags=%b div=%0d exp=0000100001/6", flags(), div_divider); end
  endtask

  task automatic test_step3();
    step(1, OP_STEP, 3, 0, 0);
    checks++; if (flags() !== F_LOAD || div_pulse !== 32'd3) begin errors++;
      $display("FAIL step3_load flags=%b pulse=%0d exp=%b/3", flags(), div_pulse, F_LOAD); end
    for (int k = 2; k <= 4; k++) begin
      step(0, OP_STOP, 0, 0, 0);
      checks++; if (flags() !== F_RUN) begin errors++;
        $display("FAIL step3_run cycle=%0d got=%b exp=%b", k, flags(), F_RUN); end
    end
    step(0, OP_STOP, 0, 0, 0);
    checks++; if (flags() !== F_DONE) begin errors++;
      $display("FAIL step3_done got=%b exp=%b", flags(), F_DONE); end
  endtask

  task automatic test_step0();
    step(1, OP_STEP, 0, 0, 0);
    checks++; if (flags() !== F_DONE) begin errors++;
      $display("FAIL step0 got=%b exp=%b", flags(), F_DONE); end
  endtask

  task automatic test_abort();
    step(1, OP_STEP, 10, 0, 0);
    step(0, OP_STOP, 0, 0, 0);
    step(0, OP_STOP, 0, 0, 0);
    step(0, OP_STOP, 0, 0, 0);
    checks++; if (flags() !== F_RUN) begin errors++;
      $display("FAIL abort_pre got=%b exp=%b", flags(), F_RUN); end
    step(0, OP_STOP, 0, 1, 0);
    checks++; if (flags() !== F_ABORTED) begin errors++;
      $display("FAIL abort_result got=%b exp=%b", flags(), F_ABORTED); end
  endtask

  task automatic test_free();
    step(1, OP_FREE, 0, 0, 0);
    checks++; if (flags() !== F_FREE) begin errors++;
      $display("FAIL free_enter got=%b exp=%b", flags(), F_FREE); end
    step(1, OP_SET, 1, 0, 0);
    checks++; if (flags() !== F_FREEERR || div_divider !== 32'd6) begin errors++;
      $display("FAIL free_set1 flags=%b div=%0d exp=%b/6", flags(), div_divider, F_FREEERR); end
    step(1, OP_STEP, 4, 0, 0);
    checks++; if (flags() !== F_FREEERR) begin errors++;
      $display("FAIL free_step got=%b exp=%b", flags(), F_FREEERR); end
    step(1, OP_SET, 9, 0, 0);
    checks++; if (div_divider !== 32'd9 || state_o !== 2'b11) begin errors++;
      $display("FAIL free_live_set div=%0d state=%b exp=9/11", div_divider, state_o); end
    step(1, OP_STOP, 0, 0, 0);
    checks++; if (flags() !== F_DONE) begin errors++;
      $display("FAIL free_stop got=%b exp=%b", flags(), F_DONE); end
  endtask

  task automatic test_reset_mid_step();
    step(1, OP_STEP, 5, 0, 0);
    step(0, OP_STOP, 0, 0, 0);
    step(1, OP_STOP, 0, 1, 1);
    checks++; if (flags() !== F_RESET || div_divider !== CB'(DEF) || div_pulse !== '0) begin
      errors++;
      $display("FAIL reset_mid flags=%b div=%0d pulse=%0d exp=%b/%0d/0",
               flags(), div_divider, div_pulse, F_RESET, DEF); end
    for (int k = 0; k < 8; k++) begin
      step(0, OP_STOP, 0, 0, 0);
      checks++; if (flags() !== F_RESET) begin errors++;
        $display("FAIL reset_mid_quiet cycle=%0d got=%b exp=%b", k, flags(), F_RESET); end
    end
  endtask

  task automatic test_random();
    logic        v, ab, rst;
    logic [1:0]  op;
    logic [31:0] d;
    for (int i = 0; i < 600; i++) begin
      v   = 1'($urandom_range(0, 1));
      op  = 2'($urandom_range(0, 3));
      ab  = ($urandom_range(0, 15) == 0);
      rst = ($urandom_range(0, 99) == 0);
      if (op == OP_STEP)                 d = $urandom_range(0, 12);
      else if ($urandom_range(0, 3) == 0) d = $urandom_range(0, 3);
      else                               d = $urandom;
      step(v, op, d, ab, rst);
      checks++; if (flags() !== exp_flags()) begin errors++;
        $display("FAIL rand_flags i=%0d got=%b exp=%b", i, flags(), exp_flags()); end
      checks++; if (div_divider !== m_div || div_pulse !== m_pulse) begin errors++;
        $display("FAIL rand_data i=%0d div=%0d/%0d pulse=%0d/%0d (got/exp)",
                 i, div_divider, m_div, div_pulse, m_pulse); end
    end
  endtask

  initial begin
    cif.cmd_valid = 1'b0; cif.cmd_op = 2'b00; cif.cmd_data = '0; cif.abort = 1'b0;
    e_done = 1'b0; e_abt = 1'b0; e_err = 1'b0; e_wp = 1'b0; e_state = 2'b00;
    test_reset();
    test_set_div();
    test_step3();
    test_step0();
    test_abort();
    test_free();
    test_reset_mid_step();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/clk_div_sequencer.md
CLK_DIV_SEQUENCER -- requirements
Module: clk_div_sequencer

Interface
REQ-001 The block SHALL have parameter COUNTER_BITS, default 32, setting the width of the divider ratio.
REQ-002 The block SHALL have parameter PULSE_CONTROL_BITS, default 32, setting the width of the step pulse count.
REQ-003 The block SHALL have parameter DEFAULT_DIVIDER, default 2, giving the divider ratio loaded at reset.
REQ-004 The block SHALL have port clk, input, 1 bit: the single clock; all logic SHALL be on its rising edge.
REQ-005 The block SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-006 The block SHALL have port cmd_valid, input, 1 bit: a command is presented.
REQ-007 The block SHALL have port cmd_ready, output, 1 bit: a command is accepted when both cmd_valid and cmd_ready are 1.
REQ-008 The block SHALL have port cmd_op, input, 2 bits: 00 STOP, 01 SET_DIV, 10 STEP, 11 FREE_RUN.
REQ-009 The block SHALL have port cmd_data, input, 32 bits: the divider ratio (SET_DIV) or pulse count (STEP); zero-extended or truncated to the target width.
REQ-010 The block SHALL have port abort, input, 1 bit: terminates a STEP in progress.
REQ-011 The block SHALL have divider-control outputs div_write_pulse (1 bit), div_option (1 bit; 0 pulse, 1 auto), div_out_enable (1 bit), div_divider (COUNTER_BITS) and div_pulse (PULSE_CONTROL_BITS).
REQ-012 The block SHALL have outputs done (1 bit, one-cycle completion strobe), aborted (1 bit, qualifies done), err (1 bit, one-cycle rejected-command strobe) and busy (1 bit).
REQ-013 The block SHALL have output state_o, 2 bits: 00 IDLE, 01 STEP_LOAD, 10 STEP_RUN, 11 FREE.

Function
REQ-014 The block SHALL register all outputs except cmd_ready, which SHALL be decoded from the registered state: 1 in IDLE and FREE, 0 in STEP_LOAD and STEP_RUN.
REQ-015 In IDLE, the block SHALL drive div_out_enable=0 and div_option=0.
REQ-016 In STEP_LOAD and STEP_RUN, the block SHALL drive div_out_enable=1 and div_option=0.
REQ-017 In FREE, the block SHALL drive div_out_enable=1 and div_option=1.
REQ-018 busy SHALL be 1 in every state other than IDLE.
REQ-019 When SET_DIV is accepted with cmd_data>=2, div_divider SHALL take the value on the next cycle, done SHALL pulse on that cycle, and the state SHALL be unchanged; this applies in IDLE and in FREE, where the update is live.
REQ-020 When SET_DIV is accepted with cmd_data<2, div_divider SHALL be unchanged and err SHALL pulse on the next cycle.
REQ-021 When STEP with N>0 is accepted in IDLE at cycle T: at T+1 the state SHALL be STEP_LOAD, with div_write_pulse=1 for exactly that cycle, div_pulse=N, and an internal remaining counter loaded with N.
REQ-022 The state SHALL be STEP_RUN at T+2, remaining SHALL decrement once per cycle, and when remaining==1 the next state SHALL be IDLE with done=1 and aborted=0; STEP_RUN therefore lasts exactly N cycles and done occurs at T+N+2.
REQ-023 When STEP with N=0 is accepted, div_write_pulse SHALL NOT be asserted, the state SHALL remain IDLE, and done SHALL pulse at T+1.
REQ-024 When STEP is accepted in FREE, it SHALL be ignored, err SHALL pulse on the next cycle, and the state SHALL remain FREE.
REQ-025 When FREE_RUN is accepted, the state SHALL be FREE on the next cycle; in FREE, FREE_RUN SHALL have no effect.
REQ-026 When STOP is accepted in FREE, the next state SHALL be IDLE with done=1; in IDLE, STOP SHALL pulse done only.
REQ-027 When abort=1 in STEP_LOAD or STEP_RUN, the next state SHALL be IDLE with div_out_enable=0, done=1 and aborted=1; abort SHALL be ignored in IDLE and FREE.
REQ-028 The remaining counter SHALL never wrap below 0.
REQ-029 done, err and aborted SHALL be mutually exclusive strobes, except that aborted=1 SHALL occur only together with done=1.

Reset
REQ-030 When reset=1 at a rising edge, the block SHALL enter IDLE and drive div_divider=DEFAULT_DIVIDER, div_pulse=0, div_write_pulse=0, div_option=0, div_out_enable=0, done=0, aborted=0, err=0, busy=0 and remaining=0.
REQ-031 Reset SHALL take priority over cmd_valid and abort, including reset in the middle of a STEP (the output is gated immediately and done is not pulsed).

Verification
REQ-032 A bench SHALL cover: reset, then SET_DIV 6 accepted at cycle 0 -> div_divider=6 at cycle 1, done=1 at cycle 1, state IDLE.
REQ-033 A bench SHALL cover: STEP 3 accepted at cycle 0 -> div_write_pulse=1 and div_pulse=3 at cycle 1 only, div_out_enable=1 for cycles 1-4, cmd_ready=0 for cycles 1-4, done=1 and aborted=0 at cycle 5.
REQ-034 A bench SHALL cover: STEP 0 -> no div_write_pulse, done=1 at the next cycle.
REQ-035 A bench SHALL cover: STEP 10, then abort at the third STEP_RUN cycle -> div_out_enable=0 and done=aborted=1 on the next cycle, state IDLE.
REQ-036 A bench SHALL cover: FREE_RUN, then SET_DIV 1 -> err=1 with div_divider unchanged; then STEP -> err=1 with state FREE; then STOP -> done=1 and div_out_enable=0.
REQ-037 A bench SHALL cover: reset asserted at cycle 2 of STEP 5 -> all outputs at reset values at the next cycle, and no done pulse.
